// File: rtl/cnt_led_pkg.sv
// Shared types and default sizes for the CNT_LED counter/LED engine.
package cnt_led_pkg;

    typedef enum logic [1:0] {
        MODE_BIN    = 2'd0,
        MODE_ROT    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_STATIC = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int DEF_LED_W = 8;
    localparam int DEF_CNT_W = 32;
    localparam int DEF_PWM_W = 8;

endpackage

// File: rtl/cnt_led_prescaler.sv
// Step prescaler: counts 0..prescale while run is high and ticks on the terminal count.
module cnt_led_prescaler
    import cnt_led_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    input  logic [CNT_W-1:0] prescale,
    output logic             tick
);

    logic [CNT_W-1:0] pcnt;
    logic             at_term;

    // >= so that lowering prescale below the current count still terminates
    assign at_term = (pcnt >= prescale);
    assign tick    = run && !clr && at_term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (run) begin
            pcnt <= at_term ? '0 : pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/cnt_led_core.sv
// Counter/LED engine behind the CNT_LED register slave: prescaled step counter,
// four LED display modes, sticky wrap status. Optional PWM dimming: CNT_LED_PWM_EN.
module cnt_led_core
    import cnt_led_pkg::*;
#(
    parameter int LED_W = DEF_LED_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int PWM_W = DEF_PWM_W
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             cfg_enable,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_prescale,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [LED_W-1:0] cfg_pattern,
    input  logic [PWM_W-1:0] cfg_duty,
    input  logic             clr_pulse,
    input  logic             sts_clr,
    output logic [LED_W-1:0] led,
    output logic [CNT_W-1:0] cnt_value,
    output logic             step_pulse,
    output logic             sts_wrap,
    output state_e           dbg_state
);

    // cfg_* are quasi-static levels; clr_pulse and sts_clr are single-cycle strobes, no handshake.
    state_e           state, state_nxt;
    mode_e            mode, mode_q;
    logic             run, tick, wrap, mode_chg;
    logic [CNT_W-1:0] cnt_nxt;
    logic [LED_W-1:0] seed, sr, rot_nxt, bnc, bnc_nxt, led_raw;
    logic             bnc_up;

    assign mode      = mode_e'(cfg_mode);
    assign run       = (state == ST_RUN);
    assign dbg_state = state;
    assign mode_chg  = (mode != mode_q);
    assign seed      = (cfg_pattern == '0) ? LED_W'(1) : cfg_pattern;
    assign wrap      = (cnt_value >= cfg_period);
    assign cnt_nxt   = wrap ? '0 : cnt_value + 1'b1;
    assign rot_nxt   = {sr[LED_W-2:0], sr[LED_W-1]};
    assign bnc_nxt   = bnc_up ? (bnc << 1) : (bnc >> 1);

    cnt_led_prescaler #(.CNT_W(CNT_W)) u_prescaler (
        .clk      (ACLK),
        .rst      (ARESET),
        .run      (run),
        .clr      (clr_pulse),
        .prescale (cfg_prescale),
        .tick     (tick)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr_pulse) begin
            state_nxt = cfg_enable ? ST_RUN : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: if (cfg_enable)  state_nxt = ST_RUN;
                ST_RUN:           if (!cfg_enable) state_nxt = ST_HOLD;
                default:          state_nxt = ST_IDLE;
            endcase
        end
    end

    // A wrap on the same edge as sts_clr keeps the flag set.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt_value  <= '0;
            step_pulse <= 1'b0;
            sts_wrap   <= 1'b0;
        end else begin
            step_pulse <= tick;
            if (clr_pulse)  cnt_value <= '0;
            else if (tick)  cnt_value <= cnt_nxt;
            if (tick && wrap) sts_wrap <= 1'b1;
            else if (sts_clr) sts_wrap <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            mode_q  <= MODE_BIN;
            sr      <= LED_W'(1);
            bnc     <= LED_W'(1);
            bnc_up  <= 1'b1;
            led_raw <= '0;
        end else begin
            mode_q <= mode;
            if (clr_pulse || mode_chg) begin
                sr     <= seed;
                bnc    <= LED_W'(1);
                bnc_up <= 1'b1;
            end else if (tick) begin
                sr     <= rot_nxt;
                bnc    <= bnc_nxt;
                // Turn around as soon as an endpoint is reached so it is lit for one step only
                bnc_up <= bnc_up ? !bnc_nxt[LED_W-1] : bnc_nxt[0];
            end
            if (mode == MODE_STATIC) begin
                led_raw <= cfg_pattern;
            end else if (tick) begin
                case (mode)
                    MODE_BIN:    led_raw <= cnt_nxt[LED_W-1:0];
                    MODE_ROT:    led_raw <= rot_nxt;
                    MODE_BOUNCE: led_raw <= bnc_nxt;
                    default:     led_raw <= led_raw;
                endcase
            end
        end
    end

`ifdef CNT_LED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;
    logic             pwm_on;

    // The compare alone can never reach full on, so all-ones duty is forced on.
    assign pwm_on = (cfg_duty == '1) || (pwm_cnt < cfg_duty);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            pwm_cnt <= '0;
            led     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            led     <= pwm_on ? led_raw : '0;
        end
    end
`else
    logic unused_duty;

    assign unused_duty = ^cfg_duty;
    assign led         = led_raw;
`endif

endmodule
